// File: rtl/gaussian_pkg.sv
// gaussian_pkg: shared widths and 1-2-1 kernel constants for the 3x3 Gaussian filter
package gaussian_pkg;
    localparam int PIX_W  = 8;
    localparam int VSUM_W = 10;
    localparam int HSUM_W = 12;
    localparam int unsigned K0 = 1;
    localparam int unsigned K1 = 2;
    localparam int unsigned K2 = 1;
    localparam int unsigned NORM_SHIFT = 4;
    localparam int unsigned ROUND = 8;
endpackage

// File: rtl/gaussian_col_sum.sv
// gaussian_col_sum: combinational 1-2-1 weighted sum of three unsigned inputs
module gaussian_col_sum
    import gaussian_pkg::*;
#(
    parameter int IW = PIX_W,
    parameter int OW = VSUM_W
) (
    input  logic [IW-1:0] a_i,
    input  logic [IW-1:0] b_i,
    input  logic [IW-1:0] c_i,
    output logic [OW-1:0] sum_o
);
    assign sum_o = OW'(K0 * 32'(a_i) + K1 * 32'(b_i) + K2 * 32'(c_i));
endmodule

// File: rtl/gaussian_3x3_filter.sv
// gaussian_3x3_filter: streaming 3x3 Gaussian (1-2-1 separable, /16 rounded) with zero-padded left/right borders
module gaussian_3x3_filter
    import gaussian_pkg::*;
#(
    parameter int DW = PIX_W,
    parameter int WW = 11,
    parameter int HW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [WW-1:0] img_width,
    input  logic [HW-1:0] img_height,
    input  logic          valid_i,
    input  logic [DW-1:0] prev_line_data_i,
    input  logic [DW-1:0] cur_line_data_i,
    input  logic [DW-1:0] next_line_data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          eol_o,
    output logic          eof_o
);
    logic [VSUM_W-1:0] vs, c_q, c_d, r_q, r_d, wl_q, wl_d, wc_q, wc_d, wr_q, wr_d;
    logic [HSUM_W-1:0] hs, s_q, s_d;
    logic [WW-1:0]     col_q, col_d;
    logic [HW-1:0]     line_q, line_d;
    logic [DW-1:0]     data_q, data_d;
    logic tail_q, tail_d, v1_q, v1_d, eol1_q, eol1_d, eof1_q, eof1_d;
    logic v2_q, v2_d, eol2_q, eol2_d, eof2_q, eof2_d;
    logic valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
    logic last_col, last_line, gen;

    gaussian_col_sum #(.IW(DW), .OW(VSUM_W)) u_vsum (
        .a_i   (prev_line_data_i),
        .b_i   (cur_line_data_i),
        .c_i   (next_line_data_i),
        .sum_o (vs)
    );

    gaussian_col_sum #(.IW(VSUM_W), .OW(HSUM_W)) u_hsum (
        .a_i   (wl_q),
        .b_i   (wc_q),
        .c_i   (wr_q),
        .sum_o (hs)
    );

    // c_q/r_q are the centre and right window columns; the output window is (C, R, new column or 0 for the tail)
    always_comb begin
        last_col  = col_q == img_width - WW'(1);
        last_line = line_q == img_height - HW'(1);
        gen       = (valid_i && col_q != '0) || tail_q;
        col_d     = valid_i ? (last_col ? '0 : col_q + WW'(1)) : col_q;
        c_d       = valid_i ? (col_q == '0 ? '0 : r_q) : c_q;
        r_d       = valid_i ? vs : r_q;
        tail_d    = valid_i && last_col;
        line_d    = tail_q ? (last_line ? '0 : line_q + HW'(1)) : line_q;
        wl_d      = gen ? c_q : wl_q;
        wc_d      = gen ? r_q : wc_q;
        wr_d      = gen ? (tail_q ? '0 : vs) : wr_q;
        v1_d      = gen;
        eol1_d    = tail_q;
        eof1_d    = tail_q && last_line;
        s_d       = v1_q ? hs + HSUM_W'(ROUND) : s_q;
        v2_d      = v1_q;
        eol2_d    = eol1_q;
        eof2_d    = eof1_q;
        data_d    = v2_q ? DW'(s_q >> NORM_SHIFT) : data_q;
        valid_d   = v2_q;
        eol_d     = eol2_q;
        eof_d     = eof2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q   <= '0;
            line_q  <= '0;
            c_q     <= '0;
            r_q     <= '0;
            tail_q  <= 1'b0;
            wl_q    <= '0;
            wc_q    <= '0;
            wr_q    <= '0;
            v1_q    <= 1'b0;
            eol1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            s_q     <= '0;
            v2_q    <= 1'b0;
            eol2_q  <= 1'b0;
            eof2_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            line_q  <= line_d;
            c_q     <= c_d;
            r_q     <= r_d;
            tail_q  <= tail_d;
            wl_q    <= wl_d;
            wc_q    <= wc_d;
            wr_q    <= wr_d;
            v1_q    <= v1_d;
            eol1_q  <= eol1_d;
            eof1_q  <= eof1_d;
            s_q     <= s_d;
            v2_q    <= v2_d;
            eol2_q  <= eol2_d;
            eof2_q  <= eof2_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign eol_o   = eol_q;
    assign eof_o   = eof_q;
endmodule

// File: doc/gaussian_3x3_filter.md
Name: gaussian_3x3_filter

Overview:
- Sits directly downstream of the 3-line buffer.
- Consumes one column of three vertically aligned pixels per valid_i: previous, current and next line. Vertical top/bottom borders arrive already zero-padded.
- Forms the 3x3 window, zero-pads left/right borders, applies the 1-2-1 separable Gaussian kernel (sum/16, rounded) and emits one 8-bit pixel per input column.
- Also emits end-of-line and end-of-frame flags for the downstream writer.

Parameters:
- DW, 8, pixel data width.
- WW, 11, width of img_width and column counter.
- HW, 10, width of img_height and line counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- img_width  in  WW  pixels per line, >=1. Static while a frame is in flight.
- img_height  in  HW  lines per frame, >=1. Static while a frame is in flight.
- valid_i  in  1  column qualifier. No backpressure; gaps between columns allowed.
- prev_line_data_i  in  DW  pixel from line y-1 (0 at top border).
- cur_line_data_i  in  DW  pixel from line y.
- next_line_data_i  in  DW  pixel from line y+1 (0 at bottom border).
- valid_o  out  1  output pixel qualifier.
- data_o  out  DW  filtered pixel.
- eol_o  out  1  high with the last pixel of each output line.
- eof_o  out  1  high with the last pixel of the frame; implies eol_o.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - valid_o, data_o, eol_o, eof_o = 0.
  - Column/line counters, window registers, tail flag and pipeline registers cleared.
  - A partial line or frame in progress is discarded; nothing is emitted for it.
- Vertical stage, on valid_i: vs = prev + 2*cur + next, 10 bits unsigned (max 1020).
- Window:
  - Three vertical-sum registers L, C, R. Each accepted column shifts L<=C, C<=R, R<=vs.
  - At column 0, L and C are loaded as 0 (left border zero).
- Column counter col_cnt counts accepted columns 0..img_width-1 and wraps to 0.
- Output generation:
  - Accepted column c>=1: generate the output for column c-1 using window (L, C, R=vs_c).
  - Accepted column 0: generates no output. This frees the cycle needed by the tail.
  - Accepted column img_width-1: also sets the tail flag.
  - Tail flag: on the next clock, the output for column img_width-1 is generated from window (C, R, 0), regardless of valid_i. A coincident valid_i is necessarily column 0 of the next line, so there is never more than one output per cycle.
  - img_width=1: column 0 is also the last column. The tail uses window (0, vs, 0).
- Horizontal stage:
  - s = L + 2*C + R + 8, 12 bits unsigned (max 4088).
  - data = s[11:4]. No saturation is needed.
- Latency:
  - Output for column c<img_width-1: valid_o high exactly 3 clocks after the valid_i of column c+1.
  - Output for the last column: valid_o high exactly 3 clocks after the tail cycle, i.e. 4 clocks after the last valid_i.
  - Output order equals column order. Throughput is 1 pixel/clock sustained.
- Line/frame flags:
  - Output line counter 0..img_height-1 increments on each tail output and wraps to 0.
  - eol_o = 1 on every tail output.
  - eof_o = 1 on the tail output when line counter == img_height-1.
- valid_i gaps mid-line: window holds and no output is generated. The tail still fires one clock after the last column.
- data_o holds its last value when valid_o = 0.

Decomposition:
- Shared package gaussian_pkg holds:
  - kernel weights (1, 2, 1), normalisation shift 4, rounding constant 8;
  - DW, vertical-sum width 10, horizontal-sum width 12.
- One sub-module, gaussian_col_sum: combinational 1-2-1 weighted sum of three DW inputs. Instantiated for the vertical stage; reused for the horizontal stage with 10-bit inputs via a width parameter.

Test Plan:
- Flat field: width 4, height 3, all inputs 100 continuous.
  - Interior output = 100.
  - Left/right edge outputs = (1200+8)>>4 = 75.
  - 12 outputs total; eol_o on outputs 4/8/12; eof_o only on output 12.
- Impulse: width 5, cur=160 at column 2 only, others 0.
  - Outputs 0, 20, 40, 20, 0 (10+8>>4=1? no: 160*2=320, 320*2+8=648>>4=40; 320+8>>4=20).
  - Latency: first output 3 clocks after column 1 accepted.
- Back-to-back lines: width 3 continuous across a line boundary, cur = 255, prev = next = 255.
  - Tail output and the first column of the next line do not collide; exactly one valid_o per clock.
  - Values 191, 255, 191.
- Gappy input: width 4, valid_i toggled every other clock.
  - Output values identical to the continuous run.
  - Tail output 4 clocks after the last valid_i.
- Width 1, height 2, inputs (10, 20, 30).
  - Each output = ((10+40+30)*2+8)>>4 = 10.
  - Both outputs carry eol_o; the second carries eof_o.
- Reset mid-line: width 8, assert reset_n low after column 3.
  - Outputs drop to 0 asynchronously; no further outputs from the aborted line.
  - A fresh line after release starts at column 0 with correct values.
